// File: rtl/bcd_to_binary_seq.sv
// Sequential three-digit BCD to binary converter using the reverse double-dabble
// algorithm: one right shift per cycle with a -3 correction on every BCD nibble.
module bcd_to_binary_seq #(
   parameter int ITER = 10
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            start,
   input  logic [11:0]     bcd_in,
   output logic            busy,
   output logic            done,
   output logic [ITER-1:0] bin_out,
   output logic            error
);

   localparam int CNT_W = $clog2(ITER + 1);
   localparam int CAT_W = 12 + ITER;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SHIFT  = 2'd1,
      FINISH = 2'd2
   } state_t;

   state_t           state_reg;
   state_t           state_next;
   logic [11:0]      work_reg;
   logic [ITER-1:0]  acc_reg;
   logic [CNT_W-1:0] cnt_reg;
   logic [ITER-1:0]  bin_reg;
   logic             error_reg;

   logic [2:0]       nibble_bad;
   logic             in_invalid;
   logic             last_iter;
   logic [CAT_W-1:0] cat_shift;
   logic [11:0]      work_shift;
   logic [11:0]      work_adj;
   logic [ITER-1:0]  acc_shift;

   // The working register feeds its LSB into the accumulator MSB on every shift.
   assign cat_shift  = {work_reg, acc_reg} >> 1;
   assign work_shift = cat_shift[CAT_W-1:ITER];
   assign acc_shift  = cat_shift[ITER-1:0];

   generate
      for (genvar gi = 0; gi < 3; gi++) begin : g_nibble
         assign nibble_bad[gi] = (bcd_in[gi*4 +: 4] > 4'd9);
         // A nibble at 8 or more after the shift carried a ten's half-weight; -3 restores BCD.
         assign work_adj[gi*4 +: 4] = (work_shift[gi*4 +: 4] >= 4'd8)
                                      ? (work_shift[gi*4 +: 4] - 4'd3)
                                      : work_shift[gi*4 +: 4];
      end
   endgenerate

   assign in_invalid = |nibble_bad;
   assign last_iter  = (cnt_reg == CNT_W'(ITER - 1));

   always_comb begin
      state_next = state_reg;
      case (state_reg)
         IDLE: begin
            if (start) begin
               state_next = in_invalid ? FINISH : SHIFT;
            end
         end
         SHIFT: begin
            if (last_iter) begin
               state_next = FINISH;
            end
         end
         FINISH:  state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_reg <= IDLE;
         work_reg  <= '0;
         acc_reg   <= '0;
         cnt_reg   <= '0;
         bin_reg   <= '0;
         error_reg <= 1'b0;
      end else begin
         state_reg <= state_next;
         case (state_reg)
            IDLE: begin
               if (start) begin
                  work_reg  <= bcd_in;
                  acc_reg   <= '0;
                  cnt_reg   <= '0;
                  error_reg <= in_invalid;
                  // Invalid requests complete next cycle, so the zero result is published now.
                  if (in_invalid) begin
                     bin_reg <= '0;
                  end
               end
            end
            SHIFT: begin
               work_reg <= work_adj;
               acc_reg  <= acc_shift;
               cnt_reg  <= cnt_reg + CNT_W'(1);
               if (last_iter) begin
                  bin_reg <= acc_shift;
               end
            end
            default: ;
         endcase
      end
   end

   assign busy    = (state_reg == SHIFT);
   assign done    = (state_reg == FINISH);
   assign bin_out = bin_reg;
   assign error   = error_reg;

`ifndef SYNTHESIS
   // Every BCD bit must have been shifted out by the end of a valid conversion.
   work_clear_at_finish: assert property (@(posedge clk) disable iff (reset)
      (state_reg == FINISH && !error_reg) |-> (work_reg == '0));
`endif

endmodule

// File: tb/tb_bcd_to_binary_seq.sv
// Self-checking bench for bcd_to_binary_seq: vector table, hand sequences for
// mid-conversion corner cases, exhaustive valid sweep and random invalid codes.
module tb_bcd_to_binary_seq;

   logic        clk = 1'b0;
   logic        reset;
   logic        start;
   logic [11:0] bcd_in;
   logic        busy;
   logic        done;
   logic [9:0]  bin_out;
   logic        error;

   int n_tests = 0;
   int n_fail  = 0;

   typedef struct {
      logic [11:0] bcd;
      int          exp_bin;
      bit          exp_err;
   } vec_t;

   vec_t vecs[8];

   bcd_to_binary_seq #(.ITER(10)) dut (
      .clk     (clk),
      .reset   (reset),
      .start   (start),
      .bcd_in  (bcd_in),
      .busy    (busy),
      .done    (done),
      .bin_out (bin_out),
      .error   (error)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input int act, input int exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   function automatic void ref_model(input logic [11:0] bcd, output int bin, output bit err);
      int h, t, u;
      h   = int'(bcd[11:8]);
      t   = int'(bcd[7:4]);
      u   = int'(bcd[3:0]);
      err = (h > 9) || (t > 9) || (u > 9);
      bin = err ? 0 : (100 * h + 10 * t + u);
   endfunction

   // Called at a falling edge with the block idle; returns at a falling edge with the block idle.
   task automatic convert(input logic [11:0] bcd, input int exp_bin, input bit exp_err,
                          input bit glitch, input bit finish_start, input string tag);
      int cyc, busy_cnt, exp_cyc, exp_busy, n_watch, extra, hold_bad;
      bit got;
      exp_cyc  = exp_err ? 1 : 11;
      exp_busy = exp_err ? 0 : 10;
      n_watch  = (glitch || finish_start) ? 15 : 2;
      start    = 1'b1;
      bcd_in   = bcd;
      @(negedge clk);
      start    = 1'b0;
      cyc      = 1;
      got      = 1'b0;
      busy_cnt = 0;
      while (!got && cyc <= 20) begin
         if (busy) busy_cnt++;
         if (done) begin
            got = 1'b1;
         end else begin
            if (glitch && cyc == 3) begin
               start  = 1'b1;
               bcd_in = 12'h111;
            end else begin
               start = 1'b0;
            end
            @(negedge clk);
            cyc++;
         end
      end
      chk({tag, "_done_cycle"}, cyc, exp_cyc);
      chk({tag, "_busy_cycles"}, busy_cnt, exp_busy);
      chk({tag, "_busy_at_done"}, int'(busy), 0);
      chk({tag, "_bin_out"}, int'(bin_out), exp_bin);
      chk({tag, "_error"}, int'(error), int'(exp_err));
      $display("[TB] %s bcd=%03h bin_out=%0d error=%0b done_cycle=%0d", tag, bcd, bin_out, error, cyc);
      if (got && finish_start) begin
         start  = 1'b1;
         bcd_in = 12'h555;
      end
      extra    = 0;
      hold_bad = 0;
      for (int i = 0; i < n_watch; i++) begin
         @(negedge clk);
         start = 1'b0;
         if (done || busy) extra++;
         if (int'(bin_out) != exp_bin || error != exp_err) hold_bad++;
      end
      chk({tag, "_no_extra_activity"}, extra, 0);
      chk({tag, "_result_hold"}, hold_bad, 0);
   endtask

   initial begin
      int exp_bin, extra;
      bit exp_err;
      logic [11:0] bcd;

      vecs[0] = '{bcd: 12'h999, exp_bin: 999, exp_err: 1'b0};
      vecs[1] = '{bcd: 12'h000, exp_bin: 0,   exp_err: 1'b0};
      vecs[2] = '{bcd: 12'h507, exp_bin: 507, exp_err: 1'b0};
      vecs[3] = '{bcd: 12'h1A3, exp_bin: 0,   exp_err: 1'b1};
      vecs[4] = '{bcd: 12'h042, exp_bin: 42,  exp_err: 1'b0};
      vecs[5] = '{bcd: 12'hF00, exp_bin: 0,   exp_err: 1'b1};
      vecs[6] = '{bcd: 12'h00A, exp_bin: 0,   exp_err: 1'b1};
      vecs[7] = '{bcd: 12'h100, exp_bin: 100, exp_err: 1'b0};

      reset  = 1'b1;
      start  = 1'b0;
      bcd_in = 12'h000;
      repeat (3) @(negedge clk);
      chk("reset_busy", int'(busy), 0);
      chk("reset_done", int'(done), 0);
      chk("reset_bin_out", int'(bin_out), 0);
      chk("reset_error", int'(error), 0);
      reset = 1'b0;

      // Start is driven in the same cycle reset is released.
      for (int i = 0; i < 8; i++) begin
         convert(vecs[i].bcd, vecs[i].exp_bin, vecs[i].exp_err, 1'b0, 1'b0, $sformatf("vec%0d", i));
      end

      convert(12'h042, 42, 1'b0, 1'b1, 1'b0, "glitch_042");
      convert(12'h123, 123, 1'b0, 1'b0, 1'b1, "finish_start_123");
      convert(12'h2B4, 0, 1'b1, 1'b0, 1'b1, "finish_start_inv");
      convert(12'h999, 999, 1'b0, 1'b0, 1'b0, "pre_reset_999");

      // Abort a conversion partway through the shift phase.
      start  = 1'b1;
      bcd_in = 12'h876;
      @(negedge clk);
      start = 1'b0;
      repeat (4) @(negedge clk);
      chk("abort_busy_before_reset", int'(busy), 1);
      #2 reset = 1'b1;
      #1;
      chk("abort_busy", int'(busy), 0);
      chk("abort_done", int'(done), 0);
      chk("abort_bin_out", int'(bin_out), 0);
      chk("abort_error", int'(error), 0);
      extra = 0;
      repeat (3) begin
         @(negedge clk);
         if (done || busy) extra++;
      end
      chk("abort_no_done", extra, 0);
      $display("[TB] abort_876 reset mid-conversion bin_out=%0d", bin_out);
      reset = 1'b0;
      convert(12'h876, 876, 1'b0, 1'b0, 1'b0, "after_reset_876");

      for (int d = 0; d < 1000; d++) begin
         bcd = {4'(d / 100), 4'((d / 10) % 10), 4'(d % 10)};
         ref_model(bcd, exp_bin, exp_err);
         convert(bcd, exp_bin, exp_err, 1'b0, 1'b0, "sweep");
      end

      for (int r = 0; r < 40; r++) begin
         int pos;
         bcd = 12'($urandom_range(0, 4095));
         pos = $urandom_range(0, 2);
         bcd[pos*4 +: 4] = 4'($urandom_range(10, 15));
         ref_model(bcd, exp_bin, exp_err);
         convert(bcd, exp_bin, exp_err, 1'b0, 1'b0, "rand_invalid");
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
